// File: rtl/vedic_mac_acc16.sv
// vedic_mac_acc16: streaming 16x16 unsigned multiply-accumulate over framed beats.
// Pipeline: S1 operand register -> S2 Vedic product register -> S3 accumulator.
// Optional build macro MAC_SATURATE_EN: on accumulator carry-out, clamp to all-ones
// for the rest of the frame instead of wrapping.
`timescale 1ns/1ps
module vedic_mac_acc16 #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  // Urdhva-Tiryagbhyam 2x2 cell: vertical and crosswise partial products.
  function automatic logic [3:0] vm2(input logic [1:0] a, input logic [1:0] b);
    logic hi, x0, x1;
    hi = a[1] & b[1];
    x0 = a[1] & b[0];
    x1 = a[0] & b[1];
    return {hi & (x0 & x1), hi ^ (x0 & x1), x0 ^ x1, a[0] & b[0]};
  endfunction

  function automatic logic [7:0] vm4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] q0, q1, q2, q3;
    q0 = vm2(a[1:0], b[1:0]);
    q1 = vm2(a[3:2], b[1:0]);
    q2 = vm2(a[1:0], b[3:2]);
    q3 = vm2(a[3:2], b[3:2]);
    return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
  endfunction

  function automatic logic [15:0] vm8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q0, q1, q2, q3;
    q0 = vm4(a[3:0], b[3:0]);
    q1 = vm4(a[7:4], b[3:0]);
    q2 = vm4(a[3:0], b[7:4]);
    q3 = vm4(a[7:4], b[7:4]);
    return {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
  endfunction

  function automatic logic [31:0] vm16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] q0, q1, q2, q3;
    q0 = vm8(a[7:0],  b[7:0]);
    q1 = vm8(a[15:8], b[7:0]);
    q2 = vm8(a[7:0],  b[15:8]);
    q3 = vm8(a[15:8], b[15:8]);
    return {16'b0, q0} + {8'b0, q1, 8'b0} + {8'b0, q2, 8'b0} + {q3, 16'b0};
  endfunction

  logic             en;
  logic             s1_v, s1_last;
  logic [15:0]      s1_a, s1_b;
  logic             s2_v, s2_last;
  logic [31:0]      s2_p;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;

  // The whole pipeline freezes only while a finished result is refused downstream.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Next accumulator value for the beat sitting in S2; the extra sum bit is the carry-out.
  always_comb begin
    sum     = {1'b0, acc} + (ACC_W+1)'(s2_p);
    ovf_nxt = ovf | sum[ACC_W];
`ifdef MAC_SATURATE_EN
    acc_nxt = ovf_nxt ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
    cnt_nxt = cnt + CNT_W'(1);
  end

  // S1 operand capture and S2 product register, valid/last flags travel with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_p    <= '0;
    end else if (en) begin
      s1_v    <= in_valid;
      s1_last <= in_last;
      s1_a    <= in_a;
      s1_b    <= in_b;
      s2_v    <= s1_v;
      s2_last <= s1_last;
      s2_p    <= vm16(s1_a, s1_b);
    end
  end

  // S3 accumulate; a last beat publishes the frame result and clears the running state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      if (s2_v) begin
        if (s2_last) begin
          out_acc <= acc_nxt;
          out_cnt <= cnt_nxt;
          out_ovf <= ovf_nxt;
          acc     <= '0;
          cnt     <= '0;
          ovf     <= 1'b0;
        end else begin
          acc     <= acc_nxt;
          cnt     <= cnt_nxt;
          ovf     <= ovf_nxt;
        end
      end
      // With en high any pending result is being taken, so only a new completion keeps it set.
      out_valid <= s2_v && s2_last;
    end
  end

endmodule
